// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Opcodes follow funct3 so the decoder can pass it straight through.
package muldiv_pkg;

  localparam int MDOP_WIDTH = 3;

  typedef enum logic [MDOP_WIDTH-1:0] {
    MDOP_MUL    = 3'd0,
    MDOP_MULH   = 3'd1,
    MDOP_MULHSU = 3'd2,
    MDOP_MULHU  = 3'd3,
    MDOP_DIV    = 3'd4,
    MDOP_DIVU   = 3'd5,
    MDOP_REM    = 3'd6,
    MDOP_REMU   = 3'd7
  } mdop_t;

  typedef enum logic [1:0] {
    MDST_IDLE = 2'd0,
    MDST_CALC = 2'd1,
    MDST_DONE = 2'd2
  } mdst_t;

  function automatic logic op_is_div(input mdop_t op);
    logic [MDOP_WIDTH-1:0] v;
    v = op;
    return v[2];
  endfunction

  // Within the divide group, bit 1 selects remainder over quotient.
  function automatic logic op_is_rem(input mdop_t op);
    logic [MDOP_WIDTH-1:0] v;
    v = op;
    return v[1];
  endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative radix-2 multiply/divide unit: one request at a time, valid/ready in and out.
// Multiply and divide share the accumulator, operand register and step counter.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [MDOP_WIDTH-1:0] i_op,
  input  logic [WIDTH-1:0]      i_a,
  input  logic [WIDTH-1:0]      i_b,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WIDTH-1:0]      o_res
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};

  mdst_t              state_r, state_s;
  mdop_t              op_r, op_s;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r, step_s, pneg_s;
  logic [WIDTH-1:0]   opnd_r, abs_a_s, abs_b_s, spec_s, fin_s, quo_s, rem_s, res_r;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH+1:0]   trial_s;
  logic               negq_r, negr_r, ready_r, valid_r;
  logic               sa_s, sb_s, neg_a_s, neg_b_s, dz_s, ovf_s, special_s, accept_s;

  assign accept_s = i_valid && ready_r;
  assign o_ready  = ready_r;
  assign o_valid  = valid_r;
  assign o_res    = res_r;

  // Request decode: operand signedness, magnitudes and the single-cycle special cases.
  always_comb begin
    op_s = mdop_t'(i_op);
    sa_s = 1'b0;
    sb_s = 1'b0;
    case (op_s)
      MDOP_MUL, MDOP_MULH, MDOP_DIV, MDOP_REM: begin sa_s = 1'b1; sb_s = 1'b1; end
      MDOP_MULHSU:                             begin sa_s = 1'b1; sb_s = 1'b0; end
      default:                                 begin sa_s = 1'b0; sb_s = 1'b0; end
    endcase
    neg_a_s   = sa_s & i_a[WIDTH-1];
    neg_b_s   = sb_s & i_b[WIDTH-1];
    abs_a_s   = neg_a_s ? -i_a : i_a;
    abs_b_s   = neg_b_s ? -i_b : i_b;
    dz_s      = op_is_div(op_s) && (i_b == '0);
    ovf_s     = ((op_s == MDOP_DIV) || (op_s == MDOP_REM)) && (i_a == SMIN) && (i_b == '1);
    special_s = dz_s || ovf_s;
    if (dz_s) begin
      spec_s = op_is_rem(op_s) ? i_a : '1;
    end else begin
      spec_s = (op_s == MDOP_DIV) ? SMIN : '0;
    end
  end

  // One radix-2 step plus sign correction of the finished value.
  always_comb begin
    sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : '0);
    trial_s = {1'b0, acc_r[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_r};
    if (op_is_div(op_r)) begin
      // Restoring divide: upper half is the partial remainder, lower half fills with quotient bits.
      step_s = trial_s[WIDTH+1] ? {acc_r[2*WIDTH-2:0], 1'b0}
                                : {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      step_s = {sum_s, acc_r[WIDTH-1:1]};
    end
    pneg_s = negq_r ? -step_s : step_s;
    quo_s  = negq_r ? -step_s[WIDTH-1:0] : step_s[WIDTH-1:0];
    rem_s  = negr_r ? -step_s[2*WIDTH-1:WIDTH] : step_s[2*WIDTH-1:WIDTH];
    case (op_r)
      MDOP_MULH, MDOP_MULHSU, MDOP_MULHU: fin_s = pneg_s[2*WIDTH-1:WIDTH];
      MDOP_DIV, MDOP_DIVU:                fin_s = quo_s;
      MDOP_REM, MDOP_REMU:                fin_s = rem_s;
      default:                            fin_s = pneg_s[WIDTH-1:0];
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      MDST_IDLE: begin
        if (accept_s) begin
          state_s = special_s ? MDST_DONE : MDST_CALC;
        end else begin
          state_s = MDST_IDLE;
        end
      end
      MDST_CALC: state_s = (cnt_r == '0) ? MDST_DONE : MDST_CALC;
      MDST_DONE: state_s = (valid_r && i_ready) ? MDST_IDLE : MDST_DONE;
      default:   state_s = MDST_IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= MDST_IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == MDST_IDLE);
      valid_r <= (state_s == MDST_DONE);
    end
  end

  // Datapath: latch operands on acceptance, iterate in CALC, hold the result through DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_r   <= MDOP_MUL;
      cnt_r  <= '0;
      acc_r  <= '0;
      opnd_r <= '0;
      negq_r <= 1'b0;
      negr_r <= 1'b0;
      res_r  <= '0;
    end else begin
      case (state_r)
        MDST_IDLE: begin
          if (accept_s) begin
            op_r   <= op_s;
            negq_r <= neg_a_s ^ neg_b_s;
            negr_r <= neg_a_s;
            cnt_r  <= CNT_TOP;
            opnd_r <= op_is_div(op_s) ? abs_b_s : abs_a_s;
            acc_r  <= {{WIDTH{1'b0}}, (op_is_div(op_s) ? abs_a_s : abs_b_s)};
            if (special_s) begin
              res_r <= spec_s;
            end
          end
        end
        MDST_CALC: begin
          acc_r <= step_s;
          if (cnt_r == '0) begin
            res_r <= fin_s;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          res_r <= res_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed table, backpressure, reset abort,
// then random requests scored against a plain-arithmetic RV32M model.
module tb_muldiv;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_ready;
  logic [2:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        o_ready, o_valid;
  logic [31:0] o_res;

  int total = 0;
  int bad   = 0;

  muldiv #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid),
    .i_ready(i_ready), .o_res(o_res)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return ((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = sa / sb; p = q; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        q = sa % sb; p = q; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Issue one request, scramble the inputs while it runs, hold i_ready low for
  // 'stall' cycles once the result is up, then complete the handshake.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int stall);
    int cyc;
    @(negedge i_clk);
    chk({tag, "_idle_ready"}, o_ready, 1);
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
    i_ready = (stall == 0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    cyc = 1;
    while (!o_valid && cyc < 100) begin
      i_op = 3'($urandom); i_a = $urandom; i_b = $urandom;
      @(posedge i_clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_res"}, o_res, exp);
    chk({tag, "_busy"}, o_ready, 0);
    for (int s = 0; s < stall; s++) begin
      i_valid = 1'b1; i_op = 3'($urandom); i_a = $urandom; i_b = $urandom;
      @(posedge i_clk); #1;
      chk({tag, "_stall_valid"}, o_valid, 1);
      chk({tag, "_stall_res"}, o_res, exp);
      chk({tag, "_stall_ready"}, o_ready, 0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    if (stall != 0) begin
      @(posedge i_clk); #1;
    end
    if (stall == 0) begin
      @(posedge i_clk); #1;
    end
    chk({tag, "_after_ready"}, o_ready, 1);
    chk({tag, "_after_valid"}, o_valid, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          lat, stall;
  } vec_t;

  vec_t dir[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_op = 3'd0; i_a = 32'd0; i_b = 32'd0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("reset_ready", o_ready, 1);
    chk("reset_valid", o_valid, 0);
    chk("reset_res", o_res, 0);

    dir.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0});
    dir.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0});
    dir.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0});
    dir.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, 0});
    dir.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0});
    dir.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0});
    dir.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        33, 0});
    dir.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         33, 0});
    dir.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0});
    dir.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0});
    dir.push_back('{3'd7, 32'd5,          32'd0,         32'd5,         1,  0});
    dir.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0});
    dir.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0});
    dir.push_back('{3'd3, 32'd6,          32'd9,         32'd0,         33, 5});
    dir.push_back('{3'd0, 32'd6,          32'd9,         32'd54,        33, 5});

    foreach (dir[i]) begin
      run_op($sformatf("dir%0d", i), dir[i].op, dir[i].a, dir[i].b, dir[i].exp, dir[i].lat, dir[i].stall);
    end

    // Abort a running operation with reset partway through CALC.
    @(negedge i_clk);
    i_valid = 1'b1; i_op = 3'd3; i_a = $urandom; i_b = $urandom; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_ready", o_ready, 1);
    chk("rst_mid_res", o_res, 0);
    repeat (30) @(posedge i_clk);
    #1;
    chk("rst_no_stale_valid", o_valid, 0);
    run_op("rst_then_mul", 3'd0, 32'd3, 32'd4, 32'd12, 33, 0);

    for (int n = 0; n < 200; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom);
      a  = pick();
      b  = pick();
      run_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, ref_res(op, a, b),
             is_special(op, a, b) ? 1 : 33, ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
